// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle. It groups the instruction-memory address/data pair,
// the branch redirect request from execute and the valid/ready handshake
// toward decode.
//   master : the fetch unit side. It drives IMEM_ADDR, INSTR_OUT, PC_OUT and VALID_OUT.
//   slave  : the environment side (memory, execute, decode). It drives the other signals.
interface instruction_fetch_unit_if;
  logic [63:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        BRANCH_TAKEN;
  logic [63:0] BRANCH_TARGET;
  logic [31:0] INSTR_OUT;
  logic [63:0] PC_OUT;
  logic        VALID_OUT;
  logic        READY_IN;

  modport master (
    output IMEM_ADDR,
    input  IMEM_DATA,
    input  BRANCH_TAKEN,
    input  BRANCH_TARGET,
    output INSTR_OUT,
    output PC_OUT,
    output VALID_OUT,
    input  READY_IN
  );

  modport slave (
    input  IMEM_ADDR,
    output IMEM_DATA,
    output BRANCH_TAKEN,
    output BRANCH_TARGET,
    input  INSTR_OUT,
    input  PC_OUT,
    input  VALID_OUT,
    output READY_IN
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter and fetch buffer stage. The stage sits directly in front of
// a combinational instruction memory. Each cycle it presents the PC on
// IMEM_ADDR. When the stage accepts a fetch, it queues the returned word
// together with its PC in a DEPTH-entry FIFO and advances the PC by 4. Decode
// drains the FIFO head through VALID_OUT/READY_IN. A taken branch flushes the
// FIFO and restarts fetch at the word-aligned target.
// Ports:
//   CLK  : single clock. All state updates on the rising edge.
//   RST  : synchronous active-high reset. It dominates redirect and handshake.
//   bus  : instruction_fetch_unit_if.master. It carries the memory, redirect and decode signals.
// Parameters:
//   RESET_PC : PC loaded on reset. It must be 4-aligned.
//   DEPTH    : number of FIFO entries. It must be a power of two and at least 2.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input logic                     CLK,
  input logic                     RST,
  instruction_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [63:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      fifo_pc_q    [DEPTH];
  logic [63:0]      fifo_pc_d    [DEPTH];
  logic [31:0]      fifo_instr_q [DEPTH];
  logic [31:0]      fifo_instr_d [DEPTH];

  logic valid;
  logic pop;
  logic push;

  always_comb begin
    valid = (count_q != '0);
    pop   = valid & bus.READY_IN;
    // A full FIFO can still accept a fetch when the head leaves on the same edge.
    push  = ~bus.BRANCH_TAKEN & ((count_q < FULL_CNT) | pop);

    // NOTE: every signal gets a default before any branch. Without a default,
    // a path that skips the assignment would infer a latch.
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    if (bus.BRANCH_TAKEN) begin
      // A redirect discards everything. A handshake in this cycle does not
      // consume the head entry.
      pc_d     = bus.BRANCH_TARGET & ~64'h3;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = pc_q;
        fifo_instr_d[wr_ptr_q] = bus.IMEM_DATA;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        pc_d                   = pc_q + 64'd4;   // wraps modulo 2^64
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // If a push and a pop happen on the same edge, the count stays the same.
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments. All flops then
  // update together from the values they held before the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the FIFO storage has no reset. A zero count masks stale entries,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge CLK) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

  assign bus.IMEM_ADDR = pc_q;
  assign bus.VALID_OUT = valid;
  assign bus.INSTR_OUT = valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign bus.PC_OUT    = valid ? fifo_pc_q[rd_ptr_q]    : 64'h0;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Program-counter and fetch-buffer stage sitting directly upstream of `instruction_memory`. It drives the memory's 64-bit byte address, captures the 32-bit instruction word returned combinationally, and queues {PC, instruction} pairs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. A taken branch/jump redirect flushes the queue and restarts fetch at the target.

## Interface
- `RESET_PC`, default 64'h0, PC loaded on reset (byte address, must be 4-aligned).
- `DEPTH`, default 2, fetch FIFO entries (power of two, ≥2).
- `CLK`  in  1  single clock, all state updates on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `IMEM_ADDR`  out  64  address to `instruction_memory.ADDR`, equals PC register.
- `IMEM_DATA`  in  32  instruction word from `instruction_memory.OUTPUT`, combinational from `IMEM_ADDR`.
- `BRANCH_TAKEN`  in  1  redirect request from execute.
- `BRANCH_TARGET`  in  64  redirect byte address.
- `INSTR_OUT`  out  32  instruction at FIFO head.
- `PC_OUT`  out  64  PC of FIFO head instruction.
- `VALID_OUT`  out  1  FIFO head holds a valid entry.
- `READY_IN`  in  1  decode accepts head this cycle.

## Operation
- State: PC register (64b), FIFO of DEPTH entries × {PC 64b, instr 32b}, read/write pointers, occupancy count (0..DEPTH).
- pop = VALID_OUT & READY_IN.
- push = !BRANCH_TAKEN & (count < DEPTH | pop).
- Normal push: entry {PC, IMEM_DATA} written at write pointer; PC ← PC + 4.
- No push (full, no pop): PC holds; IMEM_ADDR stable.
- Redirect (BRANCH_TAKEN=1): count ← 0, pointers ← 0, PC ← {BRANCH_TARGET[63:2], 2'b00}; no push that cycle; pop handshake that cycle is a no-op (entry discarded, not consumed). Redirect has priority over push, pop and full.
- Count update: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop.
- PC arithmetic modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0, no flag.
- Outputs: VALID_OUT = (count ≠ 0). INSTR_OUT/PC_OUT = head entry when valid, all-zero when empty.
- Pointers wrap modulo DEPTH.
- Reset: PC ← RESET_PC, count/pointers ← 0, FIFO contents don't-care but masked. RST dominates BRANCH_TAKEN and handshake; mid-stream reset discards all entries.

## Timing
- IMEM_ADDR combinational from PC register; IMEM_DATA must settle within the same cycle.
- Fetch latency: instruction at address A appears on INSTR_OUT with VALID_OUT=1 one cycle after IMEM_ADDR = A (when FIFO empty).
- After RST falls: first edge with RST=0 pushes RESET_PC; VALID_OUT=1 from the next cycle.
- Throughput: one instruction/cycle sustained with READY_IN=1.
- Redirect: edge with BRANCH_TAKEN=1 → next cycle VALID_OUT=0, IMEM_ADDR = target; target instruction valid one cycle later (2-cycle bubble).
- Backpressure: with READY_IN=0 FIFO fills in DEPTH cycles, then PC stalls; head outputs hold stable while VALID_OUT=1 and READY_IN=0.
- Full + pop same edge: push still accepted, count stays DEPTH, no bubble.

## Test plan
- Reset: RST=1 two cycles, RESET_PC=0 → IMEM_ADDR=0, VALID_OUT=0, INSTR_OUT=0, PC_OUT=0; after release, PC_OUT=0 with VALID_OUT=1 one cycle later.
- Streaming: READY_IN=1 for 8 cycles → PC_OUT sequence 0,4,8,…,28, INSTR_OUT matching memory words 0..7, no gaps.
- Backpressure: READY_IN=0 from start → count reaches 2, IMEM_ADDR holds 8, head stays PC 0; raise READY_IN → PC 0,4,8 delivered in order with no drop or duplicate.
- Full with simultaneous pop: FIFO full, READY_IN=1 one cycle → head advances to PC 4, PC 8 enqueued, VALID_OUT stays 1.
- Redirect: while streaming, BRANCH_TAKEN=1, BRANCH_TARGET=64'h103 → next cycle VALID_OUT=0, IMEM_ADDR=64'h100; following cycle PC_OUT=64'h100; no stale pre-branch entry ever delivered.
- Wrap and mid-reset: RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 → PCs …FF8, …FFC, 0; assert RST with FIFO non-empty → next cycle VALID_OUT=0, IMEM_ADDR=RESET_PC.
